banked_memory: RTL and testbench
================================

Name: banked_memory

Overview:
- Parametrised successor of the processor's 32x16 data/instruction memory.
- Byte-addressed, built from two byte-lane banks (even/odd) and supports word and byte accesses; byte reads are sign- or zero-extended.
- Runs a multi-cycle initialisation sequencer after reset that clears the array (or loads a boot image) and reports busy.
- Sits between the multicycle RISC datapath (address/data registers) and storage, replacing the flat single-bank memory.

Parameters:
- DATA_W, 16, word width in bits; must be even (two byte lanes of DATA_W/2).
- ADDR_W, 6, byte-address width; word count WORDS = 2**(ADDR_W-1).
- SIGN_EXT, 1, byte reads: 1 = sign-extend lane MSB into upper half, 0 = zero-extend.

Ports:
- clk  input  1  clock; all state updates on the falling edge.
- proc_rst  input  1  synchronous active-low reset, sampled on the falling edge of clk.
- address  input  ADDR_W  byte address; word index = address[ADDR_W-1:1], lane = address[0].
- in  input  DATA_W  write data; byte writes use in[DATA_W/2-1:0].
- write  input  1  active-low write strobe.
- read  input  1  active-low read strobe.
- word  input  1  1 = word access, 0 = byte access.
- out  output  DATA_W  registered read data.
- out_valid  output  1  one-cycle pulse: out updated by a read this edge.
- busy  output  1  high while the init sequencer runs; requests are ignored.
- misalign  output  1  one-cycle pulse: word access with address[0]=1 rejected.

Behaviour:
- Reset (proc_rst=0 at a falling edge): state=INIT, init pointer=0, out=0, out_valid=0, misalign=0, busy=1. Array contents are not touched on the reset edge itself.
- FSM states:
  - INIT: on each falling edge with proc_rst=1, write the init word to both lanes of word[ptr], then ptr++. After the write of word WORDS-1, go to IDLE and set busy=0 on that same edge. INIT lasts exactly WORDS edges after reset release.
  - IDLE: services strobes every edge.
  - No other states.
- Reset mid-INIT or in IDLE: return to INIT with ptr=0; init restarts from word 0.
- During INIT, read/write are ignored: out holds, out_valid=0, misalign=0.
- Word write (write=0, word=1, address[0]=0): both lanes written with in.
- Byte write (write=0, word=0): only the lane selected by address[0] is written (0 = low/even lane) with in[DATA_W/2-1:0]; the other lane is unchanged.
- Word read (read=0, word=1, address[0]=0): out <= {odd lane, even lane} on the same falling edge; out_valid=1 for that cycle.
- Byte read: out <= selected lane, extended per SIGN_EXT; out_valid=1.
- Misaligned word access (word=1, address[0]=1, either strobe low): no write, out holds, out_valid=0, misalign=1 for one cycle.
- Simultaneous read and write, same address: read-before-write. out returns the pre-write contents; the write completes the same edge.
- Simultaneous read and write, different addresses: both are performed.
- Both strobes high: out holds, out_valid=0.
- Address wrap: none; all 2**ADDR_W byte addresses are valid storage.

Optional Feature:
- Macro: BANKED_MEMORY_BOOT_IMAGE_EN.
- Defined: INIT loads a fixed boot program at words 0..4 = 16'h9080, 16'h02E2, 16'h22E8, 16'h22D1, 16'h12F0 (upper bits zero if DATA_W>16). All other words are cleared to 0.
- Not defined: INIT clears every word to 0.
- Cycle count and busy timing are identical in both builds.

Test Plan:
- Hold proc_rst=0 for 2 edges, then release -> busy=1 for exactly 32 edges (default parameters), then 0. Every subsequent word read returns 0, or the boot image at words 0..4 when the macro is defined (read byte addr 0 -> out=16'h9080, out_valid pulse).
- After init, word write 16'hA5C3 at addr 6, then byte write 8'h7F at addr 7 -> word read at addr 6 returns 16'h7FC3.
- Byte read of addr 6 holding 16'h7F83 -> out=16'hFF83 with SIGN_EXT=1, 16'h0083 with SIGN_EXT=0.
- Word write to addr 5 -> misalign pulses 1 cycle, no storage change, out_valid=0.
- Same-edge read and write at addr 10 (old 16'h1111, new 16'h2222) -> out=16'h1111; next read at addr 10 -> 16'h2222.
- Assert proc_rst=0 at init pointer 17, issue a read during INIT -> read ignored; init restarts, busy lasts a full 32 edges after release, and word 3 is again 0 (or boot word 16'h22D1).

Source files
------------

// File: rtl/banked_memory.sv
// Byte-addressed two-lane (even/odd) memory with a post-reset init sequencer; all state on negedge clk.
// Define BANKED_MEMORY_BOOT_IMAGE_EN to preload a boot program at words 0..4 instead of clearing them.

module banked_memory_bank #(
    parameter int LANE_W = 8,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [LANE_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [LANE_W-1:0] rdata
);
    logic [LANE_W-1:0] mem [2**IDX_W];

    // Array has no reset: the init sequencer owns clearing it.
    always_ff @(negedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

module banked_memory #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 6,
    parameter int SIGN_EXT = 1
) (
    input  logic              clk,
    input  logic              proc_rst,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] in,
    input  logic              write,
    input  logic              read,
    input  logic              word,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              busy,
    output logic              misalign
);
    localparam int LANE_W = DATA_W / 2;
    localparam int IDX_W  = ADDR_W - 1;
    localparam int WORDS  = 2 ** IDX_W;

    typedef enum logic {INIT, IDLE} state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             lane;
        logic             wr;
        logic             rd;
        logic             word;
    } req_t;

    state_t                   state;
    logic [IDX_W-1:0]         ptr;
    req_t                     req;
    logic                     active, mis, do_wr, do_rd;
    logic [1:0]               lane_we;
    logic [IDX_W-1:0]         waddr;
    logic [1:0][LANE_W-1:0]   lane_wd;
    logic [1:0][LANE_W-1:0]   lane_rd;
    logic [LANE_W-1:0]        byte_sel;
    logic [DATA_W-1:0]        rdata;
    logic [DATA_W-1:0]        init_word;

    assign req    = '{idx: address[ADDR_W-1:1], lane: address[0],
                      wr: !write, rd: !read, word: word};
    assign active = (state == IDLE) && proc_rst;
    assign mis    = req.word && req.lane && (req.wr || req.rd);
    assign do_wr  = active && req.wr && !mis;
    assign do_rd  = active && req.rd && !mis;

    always_comb begin
        init_word = '0;
`ifdef BANKED_MEMORY_BOOT_IMAGE_EN
        case (int'(ptr))
            0: init_word = DATA_W'(16'h9080);
            1: init_word = DATA_W'(16'h02E2);
            2: init_word = DATA_W'(16'h22E8);
            3: init_word = DATA_W'(16'h22D1);
            4: init_word = DATA_W'(16'h12F0);
            default: init_word = '0;
        endcase
`endif
    end

    // Byte writes drive the low half of `in` onto whichever lane is enabled.
    always_comb begin
        lane_we    = '0;
        waddr      = req.idx;
        lane_wd[0] = in[LANE_W-1:0];
        lane_wd[1] = req.word ? in[DATA_W-1:LANE_W] : in[LANE_W-1:0];
        if (state == INIT && proc_rst) begin
            lane_we = 2'b11;
            waddr   = ptr;
            lane_wd = init_word;
        end else if (do_wr) begin
            lane_we = req.word ? 2'b11 : (req.lane ? 2'b10 : 2'b01);
        end
    end

    for (genvar l = 0; l < 2; l++) begin : g_lane
        banked_memory_bank #(.LANE_W(LANE_W), .IDX_W(IDX_W)) u_bank (
            .clk   (clk),
            .we    (lane_we[l]),
            .waddr (waddr),
            .wdata (lane_wd[l]),
            .raddr (req.idx),
            .rdata (lane_rd[l])
        );
    end

    // Read path sees pre-write contents, giving read-before-write on a shared edge.
    assign byte_sel = lane_rd[req.lane];
    assign rdata    = req.word ? lane_rd
                               : {{LANE_W{(SIGN_EXT != 0) && byte_sel[LANE_W-1]}}, byte_sel};

    always_ff @(negedge clk) begin
        if (!proc_rst) begin
            state     <= INIT;
            ptr       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            misalign  <= 1'b0;
            busy      <= 1'b1;
        end else begin
            out_valid <= 1'b0;
            misalign  <= 1'b0;
            case (state)
                INIT: begin
                    ptr <= ptr + IDX_W'(1);
                    if (ptr == IDX_W'(WORDS - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (mis) misalign <= 1'b1;
                    if (do_rd) begin
                        out       <= rdata;
                        out_valid <= 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_banked_memory.sv
// Directed self-checking bench for banked_memory (default parameters, either boot build).

module tb_banked_memory;
    localparam int SE = 1;

    logic        clk = 1'b0;
    logic        proc_rst;
    logic [5:0]  address;
    logic [15:0] din;
    logic        write, read, word;
    logic [15:0] out;
    logic        out_valid, busy, misalign;

    int n_chk = 0;
    int n_err = 0;
    int n;

    banked_memory #(.DATA_W(16), .ADDR_W(6), .SIGN_EXT(SE)) dut (
        .clk       (clk),
        .proc_rst  (proc_rst),
        .address   (address),
        .in        (din),
        .write     (write),
        .read      (read),
        .word      (word),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

`ifdef BANKED_MEMORY_BOOT_IMAGE_EN
    localparam logic [15:0] W0 = 16'h9080, W2 = 16'h22E8, W3 = 16'h22D1;
`else
    localparam logic [15:0] W0 = 16'h0000, W2 = 16'h0000, W3 = 16'h0000;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one request for one falling edge, then settle past the edge.
    task automatic cyc(input logic rst, input logic r, input logic w, input logic wd,
                       input logic [5:0] a, input logic [15:0] d);
        proc_rst = rst; read = r; write = w; word = wd; address = a; din = d;
        @(negedge clk); #1;
    endtask

    task automatic idle(); cyc(1'b1, 1'b1, 1'b1, 1'b1, 6'd0, 16'h0); endtask

    task automatic wait_init(input string tag);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            idle();
            n++;
        end
        check(tag, n, 32);
    endtask

    initial begin
        logic [15:0] sx;
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 6'd0, 16'h0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 6'd0, 16'h0);
        check("rst_busy", busy, 1);
        check("rst_out", out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_mis", misalign, 0);
        wait_init("init_len");

        cyc(1'b1, 1'b0, 1'b1, 1'b1, 6'd0, 16'h0);
        check("rd0", out, W0);
        check("rd0_valid", out_valid, 1);
        idle();
        check("hold_valid", out_valid, 0);
        check("hold_out", out, W0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 6'd62, 16'h0);
        check("rd62", out, 0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 6'd1, 16'h0);
        sx = (SE != 0 && W0[15]) ? {8'hFF, W0[15:8]} : {8'h00, W0[15:8]};
        check("rdb1", out, sx);

        cyc(1'b1, 1'b1, 1'b0, 1'b1, 6'd6, 16'hA5C3);
        check("wr_valid", out_valid, 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 6'd7, 16'h127F);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 6'd6, 16'h0);
        check("rd6_merge", out, 16'h7FC3);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 6'd6, 16'hEE83);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 6'd6, 16'h0);
        check("rdb6_ext", out, (SE != 0) ? 16'hFF83 : 16'h0083);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 6'd7, 16'h0);
        check("rdb7", out, 16'h007F);

        cyc(1'b1, 1'b1, 1'b0, 1'b1, 6'd5, 16'hFFFF);
        check("mis_w", misalign, 1);
        check("mis_w_valid", out_valid, 0);
        check("mis_w_out", out, 16'h007F);
        idle();
        check("mis_clear", misalign, 0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 6'd4, 16'h0);
        check("rd4_untouched", out, W2);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 6'd5, 16'h0);
        check("mis_r", misalign, 1);
        check("mis_r_out", out, W2);

        cyc(1'b1, 1'b1, 1'b0, 1'b1, 6'd10, 16'h1111);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 6'd10, 16'h2222);
        check("rbw_old", out, 16'h1111);
        check("rbw_valid", out_valid, 1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 6'd10, 16'h0);
        check("rbw_new", out, 16'h2222);

        // Reset, then interrupt the init sequence at pointer 17.
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 6'd0, 16'h0);
        check("rst2_out", out, 0);
        for (int i = 0; i < 17; i++) begin
            if (i == 5) begin
                cyc(1'b1, 1'b0, 1'b1, 1'b1, 6'd10, 16'h0);
                check("init_rd_valid", out_valid, 0);
                check("init_rd_out", out, 0);
            end else idle();
        end
        check("mid_busy", busy, 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 6'd10, 16'h0);
        check("rst3_busy", busy, 1);
        wait_init("reinit_len");
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 6'd6, 16'h0);
        check("reinit_w3", out, W3);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 6'd10, 16'h0);
        check("reinit_w5", out, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
